// File: rtl/vpu_dma.sv
// vpu_dma: multi-channel DMA that bursts bytes from an external video bus into a local line cache.
// Channels are picked round-robin; each burst holds the bus until the channel's length is exhausted.
module vpu_dma #(
  parameter int NUM_CH   = 2,
  parameter int CACHE_AW = 6,
  parameter int VA_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          AD,
  input  logic [7:0]          DI,
  output logic [7:0]          DO,
  input  logic                rw,
  input  logic                cs,
  output logic                irq,
  output logic [VA_W-1:0]     VADDR,
  input  logic [7:0]          VDATA,
  output logic                hold,
  output logic                vramcs,
  input  logic                vrambusy,
  input  logic [CACHE_AW-1:0] rd_addr,
  output logic [7:0]          rd_data
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] NCH = 4'(NUM_CH);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_ADDR = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_INC  = 3'd4;
  localparam logic [2:0] S_REL  = 3'd5;
  logic [VA_W-1:0]     r_addr [NUM_CH];
  logic [7:0]          r_step [NUM_CH];
  logic [7:0]          r_len  [NUM_CH];
  logic [7:0]          r_cnt  [NUM_CH];
  logic [CACHE_AW-1:0] r_base [NUM_CH];
  logic [CACHE_AW-1:0] r_ptr  [NUM_CH];
  logic [NUM_CH-1:0]   r_ien, r_done, r_pend, r_busy;
  logic [2:0]          r_state;
  logic                r_hold;
  logic [CW-1:0]       r_sel, r_last;
  logic [7:0]          r_cache [2**CACHE_AW];
  logic                w_ok, w_wr, w_rd, w_pick_ok, w_last;
  logic [CW-1:0]       w_ch, w_pick;
  logic [15:0]         w_a16;
  logic [7:0]          w_rdata;
  assign w_ok   = ({1'b0, AD[5:3]} < NCH);
  assign w_ch   = CW'(AD[5:3]);
  assign w_wr   = cs && !rw && w_ok;
  assign w_rd   = cs && rw && w_ok;
  assign w_a16  = 16'(r_addr[w_ch]);
  assign w_last = ({1'b0, r_cnt[r_sel]} + 9'd1) >= {1'b0, r_len[r_sel]};
  assign irq    = |(r_done & r_ien);
  assign hold   = r_hold || (r_state == S_IDLE && w_pick_ok);
  assign vramcs = r_state == S_ADDR || r_state == S_DATA || r_state == S_INC;
  assign VADDR  = r_addr[r_sel];
  always_comb begin
    w_rdata = 8'h00;
    if (w_ok)
      case (AD[2:0])
        3'd0: w_rdata = w_a16[15:8];
        3'd1: w_rdata = w_a16[7:0];
        3'd2: w_rdata = r_step[w_ch];
        3'd3: w_rdata = r_len[w_ch];
        3'd4: w_rdata = 8'(r_base[w_ch]);
        3'd5: w_rdata = {r_done[w_ch], r_ien[w_ch], 5'b0, r_busy[w_ch]};
        3'd6: w_rdata = r_cnt[w_ch];
        default: w_rdata = 8'(r_ptr[w_ch]);
      endcase
  end
  // Scan downward so the closest pending channel after r_last is the one kept.
  always_comb begin
    w_pick_ok = 1'b0;
    w_pick    = r_last;
    for (int k = NUM_CH; k >= 1; k--)
      if (r_pend[(int'(r_last) + k) % NUM_CH]) begin
        w_pick_ok = 1'b1;
        w_pick    = CW'((int'(r_last) + k) % NUM_CH);
      end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hold  <= 1'b0;
      r_sel   <= '0;
      r_last  <= CW'(NUM_CH - 1);
      DO      <= 8'h00;
      r_ien   <= '0;
      r_done  <= '0;
      r_pend  <= '0;
      r_busy  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_addr[i] <= '0;
        r_step[i] <= 8'd1;
        r_len[i]  <= 8'd0;
        r_cnt[i]  <= 8'd0;
        r_base[i] <= '0;
        r_ptr[i]  <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (w_pick_ok) begin
          r_state        <= S_REQ;
          r_hold         <= 1'b1;
          r_sel          <= w_pick;
          r_last         <= w_pick;
          r_busy[w_pick] <= 1'b1;
        end
        S_REQ:  if (!vrambusy) r_state <= S_ADDR;
        S_ADDR: r_state <= S_DATA;
        S_DATA: r_state <= S_INC;
        S_INC: begin
          r_addr[r_sel] <= r_addr[r_sel] + VA_W'(r_step[r_sel]);
          r_ptr[r_sel]  <= r_ptr[r_sel] + CACHE_AW'(1);
          r_cnt[r_sel]  <= r_cnt[r_sel] + 8'd1;
          r_state       <= w_last ? S_REL : S_ADDR;
        end
        S_REL: begin
          r_hold        <= 1'b0;
          r_pend[r_sel] <= 1'b0;
          r_busy[r_sel] <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // CPU writes follow the FSM so a reload overrides the same-cycle increment.
      if (w_wr)
        case (AD[2:0])
          3'd0: r_addr[w_ch] <= VA_W'({DI, w_a16[7:0]});
          3'd1: r_addr[w_ch] <= VA_W'({w_a16[15:8], DI});
          3'd2: r_step[w_ch] <= DI;
          3'd3: begin
            r_len[w_ch]  <= DI;
            r_cnt[w_ch]  <= 8'd0;
            r_ptr[w_ch]  <= r_base[w_ch];
            r_done[w_ch] <= DI == 8'd0;
            r_pend[w_ch] <= DI != 8'd0;
          end
          3'd4: r_base[w_ch] <= CACHE_AW'(DI);
          3'd5: r_ien[w_ch] <= DI[6];
          default: ;
        endcase
      if (w_rd && AD[2:0] == 3'd5) r_done[w_ch] <= 1'b0;
      if (r_state == S_REL) r_done[r_sel] <= 1'b1;
      if (cs && rw) DO <= w_rdata;
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == S_DATA) r_cache[r_ptr[r_sel]] <= VDATA;
    rd_data <= r_cache[rd_addr];
  end
endmodule

// File: tb/tb_vpu_dma.sv
// tb_vpu_dma: directed scenarios for vpu_dma against hand-computed results.
// External memory returns VADDR[7:0] ^ VADDR[15:8] for every address.
module tb_vpu_dma;
  logic        clk = 1'b0, rst = 1'b0;
  logic [5:0]  AD = '0, rd_addr = '0;
  logic [7:0]  DI = '0, DO, VDATA, rd_data;
  logic        rw = 1'b1, cs = 1'b0, vrambusy = 1'b0;
  logic        irq, hold, vramcs;
  logic [15:0] VADDR;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign VDATA = VADDR[7:0] ^ VADDR[15:8];

  vpu_dma dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs), .irq(irq),
    .VADDR(VADDR), .VDATA(VDATA), .hold(hold), .vramcs(vramcs), .vrambusy(vrambusy),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk); AD = a; DI = d; cs = 1'b1; rw = 1'b0;
    @(negedge clk); cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk); AD = a; cs = 1'b1; rw = 1'b1;
    @(negedge clk); cs = 1'b0; d = DO;
  endtask

  task automatic cache_rd(input logic [5:0] a, output logic [7:0] d);
    @(negedge clk); rd_addr = a;
    @(negedge clk); d = rd_data;
  endtask

  task automatic wait_burst(output int hc);
    bit seen = 0;
    hc = 0;
    for (int i = 0; i < 300; i++) begin
      if (hold) begin hc++; seen = 1; end
      else if (seen) return;
      @(negedge clk);
    end
    hc = -1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    @(negedge clk); @(negedge clk);
    checks++; if (hold !== 1'b0)   begin errors++; $display("FAIL reset_hold got=%b exp=0", hold); end
    checks++; if (vramcs !== 1'b0) begin errors++; $display("FAIL reset_vramcs got=%b exp=0", vramcs); end
    checks++; if (irq !== 1'b0)    begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (DO !== 8'h00)    begin errors++; $display("FAIL reset_do got=%h exp=00", DO); end
    rst = 1'b1;
    rd(6'h02, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_step got=%h exp=01", d); end
    wr(6'h38, 8'hAB);
    rd(6'h08, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bad_ch_write got=%h exp=00", d); end
    wr(6'h08, 8'h5C);
    rd(6'h38, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL bad_ch_read got=%h exp=00", d); end
    wr(6'h08, 8'h00);
  endtask

  task automatic test_basic;
    logic [7:0] d;
    logic [7:0] exp_c [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    int hc;
    wr(6'h00, 8'h10); wr(6'h01, 8'h00); wr(6'h03, 8'h04);
    wait_burst(hc);
    checks++; if (hc !== 15) begin errors++; $display("FAIL basic_hold_cycles got=%0d exp=15", hc); end
    checks++; if (VADDR !== 16'h1004) begin errors++; $display("FAIL basic_vaddr got=%h exp=1004", VADDR); end
    rd(6'h05, d);
    checks++; if (d !== 8'h80) begin errors++; $display("FAIL basic_status got=%h exp=80", d); end
    rd(6'h05, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL basic_status_clr got=%h exp=00", d); end
    rd(6'h06, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL basic_count got=%h exp=04", d); end
    rd(6'h07, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL basic_ptr got=%h exp=04", d); end
    for (int i = 0; i < 4; i++) begin
      cache_rd(6'(i), d);
      checks++; if (d !== exp_c[i]) begin errors++; $display("FAIL basic_cache[%0d] got=%h exp=%h", i, d, exp_c[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] d;
    logic [5:0] ca [3] = '{6'h3E, 6'h3F, 6'h00};
    logic [7:0] cv [3] = '{8'h30, 8'h33, 8'h36};
    int hc;
    wr(6'h00, 8'h20); wr(6'h01, 8'h10); wr(6'h02, 8'h03); wr(6'h04, 8'h3E); wr(6'h03, 8'h03);
    wait_burst(hc);
    checks++; if (hc !== 12) begin errors++; $display("FAIL wrap_hold_cycles got=%0d exp=12", hc); end
    checks++; if (VADDR !== 16'h2019) begin errors++; $display("FAIL wrap_vaddr got=%h exp=2019", VADDR); end
    rd(6'h07, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL wrap_ptr got=%h exp=01", d); end
    for (int i = 0; i < 3; i++) begin
      cache_rd(ca[i], d);
      checks++; if (d !== cv[i]) begin errors++; $display("FAIL wrap_cache[%h] got=%h exp=%h", ca[i], d, cv[i]); end
    end
  endtask

  task automatic test_round_robin;
    logic [15:0] seen_q [$];
    logic [15:0] lastv = 16'hFFFF;
    logic [15:0] exp_a [6] = '{16'h3000, 16'h3001, 16'h4000, 16'h4001, 16'h3002, 16'h3003};
    logic [5:0]  ca [4] = '{6'h10, 6'h11, 6'h20, 6'h21};
    logic [7:0]  cv [4] = '{8'h32, 8'h33, 8'h40, 8'h41};
    logic [7:0]  d;
    int hc;
    wr(6'h00, 8'h40); wr(6'h01, 8'h00); wr(6'h02, 8'h01); wr(6'h04, 8'h20);
    wr(6'h08, 8'h30); wr(6'h09, 8'h00); wr(6'h0C, 8'h10);
    fork
      for (int i = 0; i < 200 && seen_q.size() < 6; i++) begin
        @(negedge clk);
        if (vramcs && VADDR !== lastv) begin seen_q.push_back(VADDR); lastv = VADDR; end
      end
      begin
        wr(6'h0B, 8'h02);
        repeat (3) @(negedge clk);
        wr(6'h03, 8'h02);
        repeat (8) @(negedge clk);
        wr(6'h0B, 8'h02);
      end
    join
    wait_burst(hc);
    checks++; if (seen_q.size() !== 6) begin errors++; $display("FAIL rr_count got=%0d exp=6", seen_q.size()); end
    for (int i = 0; i < 6 && i < seen_q.size(); i++) begin
      checks++; if (seen_q[i] !== exp_a[i]) begin errors++; $display("FAIL rr_order[%0d] got=%h exp=%h", i, seen_q[i], exp_a[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      cache_rd(ca[i], d);
      checks++; if (d !== cv[i]) begin errors++; $display("FAIL rr_cache[%h] got=%h exp=%h", ca[i], d, cv[i]); end
    end
    rd(6'h05, d); rd(6'h0D, d);
  endtask

  task automatic test_busy;
    logic [7:0] d;
    int hc;
    wr(6'h00, 8'h50); wr(6'h01, 8'h00); wr(6'h04, 8'h30);
    vrambusy = 1'b1;
    wr(6'h03, 8'h01);
    for (int i = 0; i < 5; i++) begin
      checks++; if (vramcs !== 1'b0 || hold !== 1'b1) begin errors++; $display("FAIL busy_wait[%0d] got vramcs=%b hold=%b exp vramcs=0 hold=1", i, vramcs, hold); end
      @(negedge clk);
    end
    vrambusy = 1'b0;
    @(negedge clk);
    checks++; if (vramcs !== 1'b1 || VADDR !== 16'h5000) begin errors++; $display("FAIL busy_addr got vramcs=%b vaddr=%h exp 1/5000", vramcs, VADDR); end
    wait_burst(hc);
    checks++; if (hc !== 4) begin errors++; $display("FAIL busy_tail_cycles got=%0d exp=4", hc); end
    cache_rd(6'h30, d);
    checks++; if (d !== 8'h50) begin errors++; $display("FAIL busy_cache got=%h exp=50", d); end
    rd(6'h05, d);
  endtask

  task automatic test_irq;
    logic [7:0] d;
    int hc, hs;
    wr(6'h05, 8'h40); wr(6'h00, 8'h60); wr(6'h01, 8'h00); wr(6'h04, 8'h31); wr(6'h03, 8'h01);
    wait_burst(hc);
    checks++; if (hc !== 6) begin errors++; $display("FAIL irq_hold_cycles got=%0d exp=6", hc); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got=%b exp=1", irq); end
    rd(6'h05, d);
    checks++; if (d !== 8'hC0) begin errors++; $display("FAIL irq_status got=%h exp=c0", d); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    wr(6'h03, 8'h00);
    hs = 0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL zero_len_irq got=%b exp=1", irq); end
    for (int i = 0; i < 6; i++) begin
      if (hold) hs++;
      @(negedge clk);
    end
    checks++; if (hs !== 0) begin errors++; $display("FAIL zero_len_hold got=%0d exp=0", hs); end
    rd(6'h05, d);
    checks++; if (d !== 8'hC0) begin errors++; $display("FAIL zero_len_status got=%h exp=c0", d); end
    wr(6'h05, 8'h00);
  endtask

  task automatic test_rst_mid;
    logic [7:0] d;
    int hc;
    bit got = 0;
    wr(6'h00, 8'h70); wr(6'h01, 8'h00); wr(6'h04, 8'h32); wr(6'h03, 8'h01);
    wait_burst(hc);
    wr(6'h00, 8'h71); wr(6'h03, 8'h02);
    for (int i = 0; i < 50 && !got; i++) begin
      if (vramcs) got = 1; else @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL rst_mid_addr got=no_vramcs exp=vramcs"); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (hold !== 1'b0 || vramcs !== 1'b0) begin errors++; $display("FAIL rst_mid_outputs got hold=%b vramcs=%b exp 0/0", hold, vramcs); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cache_rd(6'h32, d);
    checks++; if (d !== 8'h70) begin errors++; $display("FAIL rst_mid_cache got=%h exp=70", d); end
    rd(6'h00, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_addr_reg got=%h exp=00", d); end
    rd(6'h02, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL rst_mid_step got=%h exp=01", d); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_round_robin;
    test_busy;
    test_irq;
    test_rst_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
